// File: rtl/des_round_engine.sv
// des_round_engine
// ----------------
// Iterative DES data path. Each accepted 64-bit block goes through the
// initial permutation, then sixteen Feistel rounds (one per clock), then
// the final permutation. The round keys come from an external subkey
// generator. Decryption uses the same hardware with the keys presented in
// reverse order.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request to process data_in (taken only when not busy)
//   data_in   [64:1] input block, data_in[64] is DES bit 1
//   k1..k16   [48:1] round subkeys, k[48] is subkey bit 1
//   data_out  [64:1] registered result, held until the next result
//   busy      high while rounds are executing
//   done      one-cycle pulse, data_out valid in that cycle
//
// Build option
//   DES_KEY_CAPTURE_EN  when defined, all sixteen subkeys are registered on
//                       the accepting edge, so the upstream keys may change
//                       during the operation. When undefined, the ports feed
//                       the round function directly.

module des_round_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [64:1]  data_in,
  input  logic [48:1]  k1,
  input  logic [48:1]  k2,
  input  logic [48:1]  k3,
  input  logic [48:1]  k4,
  input  logic [48:1]  k5,
  input  logic [48:1]  k6,
  input  logic [48:1]  k7,
  input  logic [48:1]  k8,
  input  logic [48:1]  k9,
  input  logic [48:1]  k10,
  input  logic [48:1]  k11,
  input  logic [48:1]  k12,
  input  logic [48:1]  k13,
  input  logic [48:1]  k14,
  input  logic [48:1]  k15,
  input  logic [48:1]  k16,
  output logic [64:1]  data_out,
  output logic         busy,
  output logic         done
);

  // Tables use DES numbering: output bit j takes input bit TABLE[j-1].
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // S1..S8, each 64 entries laid out row-major (row*16 + column).
  localparam int SBOX_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Vectors are declared [N:1] with the MSB holding DES bit 1, so DES bit p
  // of an N-bit vector sits at index N+1-p.
  function automatic logic [64:1] ip_perm(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[64-j] = x[65-IP_T[j]];
    return y;
  endfunction

  function automatic logic [64:1] fp_perm(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int j = 0; j < 64; j++) y[64-j] = x[65-FP_T[j]];
    return y;
  endfunction

  function automatic logic [48:1] e_expand(input logic [32:1] r);
    logic [48:1] y;
    y = '0;
    for (int j = 0; j < 48; j++) y[48-j] = r[33-E_T[j]];
    return y;
  endfunction

  function automatic logic [32:1] p_perm(input logic [32:1] s);
    logic [32:1] y;
    y = '0;
    for (int j = 0; j < 32; j++) y[32-j] = s[33-P_T[j]];
    return y;
  endfunction

  function automatic logic [32:1] feistel(input logic [32:1] r, input logic [48:1] k);
    logic [48:1] x;
    logic [32:1] s;
    logic [6:1]  six;
    x = e_expand(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      six = x[48-6*i -: 6];
      // Row is the outer bit pair (b1,b6), column the inner four bits.
      s[32-4*i -: 4] = SBOX_T[i*64 + int'({six[6], six[1], six[5:2]})][3:0];
    end
    return p_perm(s);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  rnd_reg;
  logic [32:1] l_reg, r_reg;
  logic [32:1] r_new;
  logic        accept;
  logic        last_round;
  logic [3:0]  key_idx;
  logic [48:1] key_sel;
  logic [48:1] key_port [16];

  assign key_port = '{k1, k2, k3, k4, k5, k6, k7, k8,
                      k9, k10, k11, k12, k13, k14, k15, k16};

  // rnd runs 1..16 during ROUND; the 4-bit subtraction maps 16 onto slot 15.
  assign key_idx    = rnd_reg[3:0] - 4'd1;
  assign last_round = (rnd_reg == 5'd16);

`ifdef DES_KEY_CAPTURE_EN
  // Snapshot of the subkeys taken when a block is accepted. These flops are
  // only ever read during ROUND, after being loaded, so they need no reset.
  logic [48:1] key_cap_reg [16];

  always_ff @(posedge clk) begin
    if (accept) key_cap_reg <= key_port;
  end

  assign key_sel = key_cap_reg[key_idx];
`else
  assign key_sel = key_port[key_idx];
`endif

  assign r_new = l_reg ^ feistel(r_reg, key_sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (last_round) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ROUND;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_reg    <= '0;
      r_reg    <= '0;
      rnd_reg  <= '0;
      data_out <= '0;
    end else if (accept) begin
      {l_reg, r_reg} <= ip_perm(data_in);
      rnd_reg        <= 5'd1;
    end else if (state_reg == ROUND) begin
      l_reg <= r_reg;
      r_reg <= r_new;
      if (last_round) begin
        // Pre-output block is R16 || L16: the halves are swapped here.
        data_out <= fp_perm({r_new, r_reg});
        rnd_reg  <= '0;
      end else begin
        rnd_reg <= rnd_reg + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
module tb_des_round_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [64:1] data_in;
  logic [48:1] kport [16];
  logic [64:1] data_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  des_round_engine dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .k1(kport[0]),   .k2(kport[1]),   .k3(kport[2]),   .k4(kport[3]),
    .k5(kport[4]),   .k6(kport[5]),   .k7(kport[6]),   .k8(kport[7]),
    .k9(kport[8]),   .k10(kport[9]),  .k11(kport[10]), .k12(kport[11]),
    .k13(kport[12]), .k14(kport[13]), .k15(kport[14]), .k16(kport[15]),
    .data_out(data_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (whole-block DES) ----------------
  int ip_q[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                  57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int e_q[$]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                  16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int p_q[$]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_q[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_q[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shift_q[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sbox_q[$] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic [47:0] ks [16];

  // Select bits of a w-bit value (DES numbering, bit 1 = MSB) listed in t.
  function automatic logic [63:0] perm(input logic [63:0] x, input int w, input int t[$]);
    logic [63:0] r;
    r = '0;
    foreach (t[j]) r = (r << 1) | 64'(x[w - t[j]]);
    return r;
  endfunction

  // Final permutation obtained by inverting the initial permutation.
  function automatic logic [63:0] inv_ip(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    foreach (ip_q[j]) r[64 - ip_q[j]] = x[63 - j];
    return r;
  endfunction

  task automatic make_keys(input logic [63:0] key);
    logic [63:0] t;
    logic [27:0] c, d;
    t = perm(key, 64, pc1_q);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      repeat (shift_q[i]) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = perm({8'h00, c, d}, 56, pc2_q);
      ks[i] = t[47:0];
    end
  endtask

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [31:0] s;
    int six, row, col;
    t = perm({32'h0, r}, 32, e_q);
    x = t[47:0] ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      six = int'((x >> (42 - 6*i)) & 48'h3f);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s = (s << 4) | 32'(sbox_q[i*64 + row*16 + col]);
    end
    t = perm({32'h0, s}, 32, p_q);
    return t[31:0];
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] blk, input bit decrypt);
    logic [63:0] t;
    logic [31:0] l, r, nl;
    t = perm(blk, 64, ip_q);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      nl = r;
      r  = l ^ f_model(r, decrypt ? ks[15-i] : ks[i]);
      l  = nl;
    end
    return inv_ip({r, l});
  endfunction

  // ---------------- checking and stimulus ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic load_keys(input bit decrypt);
    for (int i = 0; i < 16; i++) kport[i] = decrypt ? ks[15-i] : ks[i];
  endtask

  // Issues one block. Index i counts edges after the accepting edge; samples
  // are taken on the falling edge. ignore_at/zero_at inject a stray start or
  // zeroed keys at that index (-1 = never); tail cycles are watched for
  // spurious done pulses afterwards.
  task automatic run_op(input string tag, input logic [63:0] din, input logic [63:0] exp,
                        input int ignore_at, input int zero_at, input int tail);
    int lat, nbusy, novl, nextra;
    lat = -1; nbusy = 0; novl = 0; nextra = 0;
    data_in = din;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (busy) nbusy++;
      if (busy && done) novl++;
      if (done) begin
        lat = i;
      end else begin
        if (i == ignore_at) begin
          start   = 1'b1;
          data_in = '1;
        end else begin
          start = 1'b0;
        end
        if (i == zero_at) for (int j = 0; j < 16; j++) kport[j] = '0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check_eq({tag, ".latency"}, 64'(lat), 64'd16);
    check_eq({tag, ".data_out"}, data_out, exp);
    check_eq({tag, ".busy_cycles"}, 64'(nbusy), 64'd16);
    check_eq({tag, ".busy_done_overlap"}, 64'(novl), 64'd0);
    for (int i = 0; i < tail; i++) begin
      @(negedge clk);
      if (done) nextra++;
    end
    if (tail > 0) check_eq({tag, ".extra_done"}, 64'(nextra), 64'd0);
  endtask

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

  initial begin
    int ndone, gaps;
    int didx [2];
    logic [63:0] dval [2];
    logic [63:0] rkey, rpt, rct;

    rst = 1'b1; start = 1'b0; data_in = '0;
    for (int i = 0; i < 16; i++) kport[i] = '0;
    repeat (2) @(negedge clk);
    check_eq("reset.data_out", data_out, 64'd0);
    check_eq("reset.busy", 64'(busy), 64'd0);
    check_eq("reset.done", 64'(done), 64'd0);
    rst = 1'b0;

    make_keys(KAT_KEY);
    load_keys(1'b0);
    run_op("kat_encrypt", KAT_PT, KAT_CT, -1, -1, 2);
    load_keys(1'b1);
    run_op("kat_decrypt", KAT_CT, KAT_PT, -1, -1, 2);
    load_keys(1'b0);
    run_op("start_while_busy", KAT_PT, KAT_CT, 4, -1, 20);

    // Back-to-back: start held high through two operations.
    ndone = 0; gaps = 0;
    didx[0] = -1; didx[1] = -1; dval[0] = '0; dval[1] = '0;
    data_in = KAT_PT;
    start   = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 40; i++) begin
      if (done) begin
        if (ndone < 2) begin
          didx[ndone] = i;
          dval[ndone] = data_out;
        end
        ndone++;
      end
      if (i <= 33 && !busy && !done) gaps++;
      if (i == 33) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("b2b.done_count", 64'(ndone), 64'd2);
    check_eq("b2b.first_done_idx", 64'(didx[0]), 64'd16);
    check_eq("b2b.second_done_idx", 64'(didx[1]), 64'd33);
    check_eq("b2b.first_result", dval[0], KAT_CT);
    check_eq("b2b.second_result", dval[1], KAT_CT);
    check_eq("b2b.idle_gaps", 64'(gaps), 64'd0);

    // Reset in the middle of an operation.
    data_in = KAT_PT;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midreset.data_out", data_out, 64'd0);
    check_eq("midreset.busy", 64'(busy), 64'd0);
    check_eq("midreset.done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("midreset.no_done", 64'(ndone), 64'd0);
    check_eq("midreset.data_out_after", data_out, 64'd0);
    run_op("after_reset", KAT_PT, KAT_CT, -1, -1, 2);

`ifdef DES_KEY_CAPTURE_EN
    run_op("key_capture", KAT_PT, KAT_CT, -1, 2, 2);
    load_keys(1'b0);
`endif

    // Random keys and blocks against the model, both directions.
    for (int n = 0; n < 8; n++) begin
      rkey = {$urandom, $urandom};
      rpt  = {$urandom, $urandom};
      make_keys(rkey);
      rct = des_model(rpt, 1'b0);
      load_keys(1'b0);
      run_op($sformatf("rand%0d_enc", n), rpt, rct, -1, -1, 1);
      load_keys(1'b1);
      run_op($sformatf("rand%0d_dec", n), rct, des_model(rct, 1'b1), -1, -1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/des_round_engine.md
# des_round_engine

Iterative DES data-path engine that sits directly downstream of the subkey generator and consumes its sixteen 48-bit round keys. It performs one Feistel round per clock, bracketed by initial and final permutations. A block is accepted with a start/busy/done handshake and produces a 64-bit result 17 cycles later. Encrypt and decrypt use identical hardware; direction is set entirely by the order in which the subkey generator presents keys.

## Interface
Parameters: none.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to process data_in; accepted only in IDLE or DONE.
- data_in  input  [64:1]  input block; data_in[64] is DES bit 1 (MSB).
- k1 … k16  input  [48:1] each  round subkeys from the subkey generator; k[48] is subkey bit 1.
- data_out  output  [64:1]  result block, registered, same bit order as data_in.
- busy  output  1  high while rounds are executing.
- done  output  1  one-cycle pulse; data_out is valid in that cycle.

## Operation
- FSM states:
  - IDLE: waiting for start.
  - ROUND: executing rounds.
  - DONE: result valid.
- Transitions:
  - IDLE or DONE with start=1: register L,R = IP(data_in), set rnd=1, go to ROUND.
  - DONE with start=0: go to IDLE.
  - ROUND, each edge: L ← R, R ← L ^ P(S(E(R) ^ k_rnd)), rnd ← rnd+1.
  - ROUND, edge that applies round 16: register data_out = FP(R16‖L16) (halves swapped), go to DONE.
- rnd is a 5-bit counter covering 1..16. k_rnd is selected by a 16:1 mux on rnd. It never wraps within an operation and resets to 0.
- Round function: E expansion 32→48, XOR with the subkey, S1–S8 lookups (6→4 each), P permutation 32→32. All per FIPS 46-3 tables, purely combinational between the L/R registers.
- The engine always applies k1 in round 1 and k16 in round 16. For decryption, the subkey generator presents the keys in reversed order.
- start while busy=1: ignored. The operation in flight is unaffected and no request is queued.
- Without the capture feature, k1..k16 must be held stable from the accepting edge until done.
- data_out holds its value until the next result is registered or until reset.

## Timing
- Reset values: data_out=0, busy=0, done=0, state=IDLE, rnd=0, L=R=0.
- start sampled at edge T0. busy=1 from after T0 until after T0+16.
- Rounds 1..16 are applied at edges T0+1 … T0+16. data_out and done=1 become visible after T0+16, so done is high during the cycle between T0+16 and T0+17.
- Latency: 17 clock edges from accept to done. Throughput: one block per 17 cycles when start is held high through done.
- busy and done are never high together.
- Reset asserted mid-operation: immediately returns to reset values. No done is emitted, and the partial result is discarded.
- Reset released: start is accepted on the first following edge.

## Configuration
- DES_KEY_CAPTURE_EN defined: at the accepting edge, the engine registers all 16 subkeys (768 flops) and uses the registered copies for that operation. The upstream key may change any time after the accepting edge.
- DES_KEY_CAPTURE_EN undefined: subkeys are used directly from the ports and must be stable from accept until done. Port list and timing are identical in both builds.

## Test plan
- Encrypt known vector: subkeys for key 133457799BBCDFF1 in encrypt order, data_in=0123456789ABCDEF, start for 1 cycle -> done 17 edges later, data_out=85E813540F0AB405, busy high exactly 16 cycles.
- Decrypt known vector: same key with subkeys in decrypt order, data_in=85E813540F0AB405 -> data_out=0123456789ABCDEF.
- start ignored while busy: second start with data_in=FFFFFFFFFFFFFFFF at T0+5 -> single done, result still 85E813540F0AB405, no second done.
- Back-to-back: start held high continuously with the encrypt vector -> done pulses at T0+17 and T0+34, both results 85E813540F0AB405, busy low only during done cycles.
- Reset mid-operation: rst at T0+8 -> data_out=0, busy=0, no done. A fresh start then yields the correct result 17 cycles later.
- With DES_KEY_CAPTURE_EN: drive all subkeys to 0 at T0+3 -> data_out still 85E813540F0AB405.
